// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns EX memory requests into req/gnt/rvalid bus transactions,
// stalls the pipeline while one is outstanding and registers the write-back result for WB.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        mem_r_ena_i,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_r_addr_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_w_data_i,
    input  logic [31:0] inst_i,
    input  logic        reg_w_ena_i,
    input  logic [4:0]  reg_w_addr_i,
    input  logic [31:0] reg_w_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        reg_w_ena_o,
    output logic [4:0]  reg_w_addr_o,
    output logic [31:0] reg_w_data_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_w_ena_q, reg_w_ena_d;
    logic [4:0]  reg_w_addr_q, reg_w_addr_d;
    logic [31:0] reg_w_data_q, reg_w_data_d;
    logic        bus_err_q, bus_err_d;

    logic        op_valid, is_store, illegal, misaligned, op_bad, op_go, tmo_hit;
    logic [31:0] op_addr, op_wdata, rshift, load_val;
    logic [2:0]  funct3;
    logic [3:0]  be_base, op_be;

    // Only funct3 of the instruction word matters here.
    logic unused_inst;
    assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

    // Request decode: size, legality, alignment, lane placement.
    always_comb begin
        op_valid   = mem_w_ena_i | mem_r_ena_i;
        is_store   = mem_w_ena_i;
        op_addr    = is_store ? mem_w_addr_i : mem_r_addr_i;
        funct3     = inst_i[14:12];
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_base    = 4'b0000;
        op_wdata   = mem_w_data_i;
        case (funct3[1:0])
            2'b00: begin
                be_base  = 4'b0001;
                op_wdata = {4{mem_w_data_i[7:0]}};
            end
            2'b01: begin
                be_base    = 4'b0011;
                op_wdata   = {2{mem_w_data_i[15:0]}};
                misaligned = op_addr[0];
            end
            2'b10: begin
                be_base    = 4'b1111;
                misaligned = |op_addr[1:0];
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for byte/halfword loads.
        if (funct3[2] && (is_store || funct3[1])) begin
            illegal = 1'b1;
        end
        op_be  = be_base << op_addr[1:0];
        op_bad = op_valid & (illegal | misaligned);
        op_go  = op_valid & ~op_bad;
    end

    // Load lane extraction and extension from the latched offset and size.
    always_comb begin
        rshift = bus_rdata_i >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  load_val = {24'b0, rshift[7:0]};
            3'b101:  load_val = {16'b0, rshift[15:0]};
            default: load_val = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        f3_d         = f3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        reg_w_ena_d  = 1'b0;
        reg_w_addr_d = reg_w_addr_q;
        reg_w_data_d = reg_w_data_q;
        bus_err_d    = 1'b0;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        tmo_hit      = (cnt_q == TmoLast);

        unique case (state_q)
            StIdle: begin
                if (op_go) begin
                    state_d     = StReq;
                    cnt_d       = 8'd0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {op_addr[31:2], 2'b00};
                    bus_be_d    = op_be;
                    bus_wdata_d = op_wdata;
                    f3_d        = funct3;
                    off_d       = op_addr[1:0];
                    rd_d        = reg_w_addr_i;
                    stall_o     = 1'b1;
                end else if (op_bad) begin
                    misalign_o = 1'b1;
                end else begin
                    reg_w_ena_d  = reg_w_ena_i;
                    reg_w_addr_d = reg_w_addr_i;
                    reg_w_data_d = reg_w_data_i;
                end
            end
            StReq: begin
                stall_o = 1'b1;
                if (bus_gnt_i) begin
                    state_d   = StResp;
                    cnt_d     = 8'd0;
                    bus_req_d = 1'b0;
                end else if (tmo_hit) begin
                    // Abort releases the pipeline in this cycle; the error flag follows.
                    state_d   = StIdle;
                    cnt_d     = 8'd0;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    stall_o   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (bus_rvalid_i) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    if (!bus_we_q) begin
                        reg_w_ena_d  = 1'b1;
                        reg_w_addr_d = rd_q;
                        reg_w_data_d = load_val;
                    end
                end else if (tmo_hit) begin
                    state_d   = StIdle;
                    cnt_d     = 8'd0;
                    bus_err_d = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_be_q     <= 4'd0;
            bus_wdata_q  <= 32'd0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            reg_w_ena_q  <= 1'b0;
            reg_w_addr_q <= 5'd0;
            reg_w_data_q <= 32'd0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            reg_w_ena_q  <= reg_w_ena_d;
            reg_w_addr_q <= reg_w_addr_d;
            reg_w_data_q <= reg_w_data_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_be_o     = bus_be_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_err_o    = bus_err_q;
    assign reg_w_ena_o  = reg_w_ena_q;
    assign reg_w_addr_o = reg_w_addr_q;
    assign reg_w_data_o = reg_w_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-level reference model, randomized bus slave and
// decoupled monitors for bus transactions, write-backs, misalign and error pulses.
module tb_mem_lsu;

    localparam int unsigned Tmo = 255;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        mem_r_ena_i, mem_w_ena_i;
    logic [31:0] mem_r_addr_i, mem_w_addr_i, mem_w_data_i, inst_i;
    logic        reg_w_ena_i;
    logic [4:0]  reg_w_addr_i;
    logic [31:0] reg_w_data_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o, misalign_o, bus_err_o, reg_w_ena_o;
    logic [4:0]  reg_w_addr_o;
    logic [31:0] reg_w_data_o;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT_CYCLES(Tmo)) dut (
        .clk(clk), .arst_n(arst_n),
        .mem_r_ena_i(mem_r_ena_i), .mem_w_ena_i(mem_w_ena_i),
        .mem_r_addr_i(mem_r_addr_i), .mem_w_addr_i(mem_w_addr_i),
        .mem_w_data_i(mem_w_data_i), .inst_i(inst_i),
        .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 alu, 1 load, 2 store
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] alu;
    } op_t;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    int   mis_q[$];
    int   err_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    logic [7:0] ref_mem [int unsigned];
    logic [7:0] bus_mem [int unsigned];

    bit manual = 1'b0;
    bit no_gnt = 1'b0;
    int gnt_dly = 0;
    int rv_dly = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input bit act, input bit exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int unsigned a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] ref_byte(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] bus_byte(input int unsigned a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction

    task automatic set_byte(input int unsigned a, input logic [7:0] v);
        ref_mem[a] = v;
        bus_mem[a] = v;
    endtask

    // Reference model: access size in bytes, natural alignment, little-endian byte memory.
    task automatic model_op(input op_t o, output int exp_stall);
        int unsigned a, size;
        int bev;
        logic [31:0] v, wd;
        bus_t b;
        a = o.addr;
        exp_stall = 0;
        if (o.kind == 2'd0) begin
            if (o.wb_en) wb_q.push_back('{rd: o.rd, data: o.alu});
            return;
        end
        case (o.f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: size = (o.kind == 2'd1) ? 1 : 0;
            3'd5: size = (o.kind == 2'd1) ? 2 : 0;
            default: size = 0;
        endcase
        if (size == 0 || (a % size) != 0) begin
            mis_q.push_back(1);
            return;
        end
        bev = ((1 << size) - 1) << (a % 4);
        b.addr = a & ~32'd3;
        b.be = 4'(bev);
        if (o.kind == 2'd2) begin
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = o.wdata[8*(i % size) +: 8];
            for (int k = 0; k < int'(size); k++) ref_mem[a + k] = o.wdata[8*k +: 8];
            b.we = 1'b1;
            b.wdata = wd;
        end else begin
            v = 32'd0;
            for (int k = 0; k < int'(size); k++) v[8*k +: 8] = ref_byte(a + k);
            if (size < 4 && !o.f3[2] && v[8*size-1])
                for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
            b.we = 1'b0;
            b.wdata = 32'd0;
            wb_q.push_back('{rd: o.rd, data: v});
        end
        bus_q.push_back(b);
        exp_stall = gnt_dly + rv_dly + 2;
    endtask

    task automatic drive_nop();
        mem_r_ena_i = 1'b0; mem_w_ena_i = 1'b0;
        mem_r_addr_i = $urandom; mem_w_addr_i = $urandom; mem_w_data_i = $urandom;
        inst_i = $urandom;
        reg_w_ena_i = 1'b0; reg_w_addr_i = 5'd0; reg_w_data_i = 32'd0;
    endtask

    task automatic drive_op(input op_t o);
        logic [31:0] ins;
        ins = $urandom;
        ins[14:12] = o.f3;
        inst_i = ins;
        mem_r_ena_i = (o.kind == 2'd1) || (o.kind == 2'd2 && $urandom_range(0, 3) == 0);
        mem_w_ena_i = (o.kind == 2'd2);
        mem_r_addr_i = (o.kind == 2'd1) ? o.addr : $urandom;
        mem_w_addr_i = (o.kind == 2'd2) ? o.addr : $urandom;
        mem_w_data_i = o.wdata;
        reg_w_ena_i = (o.kind == 2'd0) ? o.wb_en : 1'($urandom);
        reg_w_addr_i = o.rd;
        reg_w_data_i = o.alu;
    endtask

    // Acts as ctrl: holds the op while stall_o is high, advances when it drops.
    task automatic do_op(input op_t o, input int exp_stall, output int ncyc);
        int nst;
        bit done;
        nst = 0; done = 1'b0; ncyc = 0;
        drive_op(o);
        while (!done && ncyc < 400) begin
            @(negedge clk);
            ncyc++;
            if (stall_o) nst++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        check_bit("op_accepted", done, 1'b1);
        if (exp_stall >= 0) check("stall_cycles", nst, exp_stall);
        drive_nop();
    endtask

    function automatic op_t mk(input logic [1:0] kind, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic wb_en, input logic [31:0] alu);
        op_t o;
        o.kind = kind; o.f3 = f3; o.addr = addr; o.wdata = wdata;
        o.rd = rd; o.wb_en = wb_en; o.alu = alu;
        return o;
    endfunction

    // Bus slave with programmable grant and response delays.
    int          rsp_phase = 0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr, rsp_wd;
    logic        rsp_we;
    logic [3:0]  rsp_be;

    initial begin
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (manual) begin
                rsp_phase = 0;
            end else begin
                bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
                if (rsp_phase == 0 && bus_req_o) begin
                    rsp_phase = 1; rsp_cnt = 0;
                end
                if (rsp_phase == 1) begin
                    if (!bus_req_o) begin
                        rsp_phase = 0;
                    end else if (!no_gnt && rsp_cnt == gnt_dly) begin
                        bus_gnt_i = 1'b1;
                        rsp_addr = bus_addr_o; rsp_we = bus_we_o;
                        rsp_be = bus_be_o; rsp_wd = bus_wdata_o;
                        rsp_phase = 2; rsp_cnt = 0;
                    end else begin
                        rsp_cnt++;
                    end
                end else if (rsp_phase == 2) begin
                    if (rsp_cnt == rv_dly) begin
                        bus_rvalid_i = 1'b1;
                        for (int l = 0; l < 4; l++) begin
                            if (rsp_we && rsp_be[l]) bus_mem[rsp_addr + l] = rsp_wd[8*l +: 8];
                            bus_rdata_i[8*l +: 8] = bus_byte(rsp_addr + l);
                        end
                        rsp_phase = 0;
                    end else begin
                        rsp_cnt++;
                    end
                end
            end
        end
    end

    bus_t mon_b;
    wb_t  mon_w;

    always @(negedge clk) begin
        if (arst_n) begin
            if (bus_req_o && bus_gnt_i) begin
                check_bit("bus_txn_expected", bus_q.size() > 0, 1'b1);
                if (bus_q.size() > 0) begin
                    mon_b = bus_q.pop_front();
                    check("bus_addr", bus_addr_o, mon_b.addr);
                    check("bus_we", {31'd0, bus_we_o}, {31'd0, mon_b.we});
                    check("bus_be", {28'd0, bus_be_o}, {28'd0, mon_b.be});
                    if (mon_b.we) check("bus_wdata", bus_wdata_o, mon_b.wdata);
                end
            end
            if (reg_w_ena_o) begin
                check_bit("wb_expected", wb_q.size() > 0, 1'b1);
                if (wb_q.size() > 0) begin
                    mon_w = wb_q.pop_front();
                    check("wb_addr", {27'd0, reg_w_addr_o}, {27'd0, mon_w.rd});
                    check("wb_data", reg_w_data_o, mon_w.data);
                end
            end
            if (misalign_o) begin
                check_bit("misalign_expected", mis_q.size() > 0, 1'b1);
                if (mis_q.size() > 0) void'(mis_q.pop_front());
                check_bit("misalign_no_req", bus_req_o, 1'b0);
            end
            if (bus_err_o) begin
                check_bit("bus_err_expected", err_q.size() > 0, 1'b1);
                if (err_q.size() > 0) void'(err_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        op_t o;
        int es, nc;
        drive_nop();
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_req", bus_req_o, 1'b0);
        check_bit("rst_wb_ena", reg_w_ena_o, 1'b0);
        check("rst_wb_data", reg_w_data_o, 32'd0);
        check_bit("rst_err", bus_err_o, 1'b0);
        check_bit("rst_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        arst_n = 1'b1;

        // Back-to-back ALU results, including rd=x0.
        o = mk(2'd0, 3'd0, 0, 0, 5'd5, 1'b1, 32'h0000_1234); model_op(o, es); do_op(o, es, nc);
        o = mk(2'd0, 3'd0, 0, 0, 5'd6, 1'b1, 32'hFFFF_0000); model_op(o, es); do_op(o, es, nc);
        o = mk(2'd0, 3'd0, 0, 0, 5'd0, 1'b1, 32'h0000_DEAD); model_op(o, es); do_op(o, es, nc);

        // LB at 0x103 reading 0x80, grant on the third request cycle.
        set_byte(32'h103, 8'h80);
        gnt_dly = 2; rv_dly = 0;
        o = mk(2'd1, 3'd0, 32'h103, 0, 5'd9, 1'b1, 32'h0); model_op(o, es); do_op(o, es, nc);

        // SH at 0x202, then read the word back.
        gnt_dly = 0; rv_dly = 0;
        o = mk(2'd2, 3'd1, 32'h202, 32'hABCD_1234, 5'd1, 1'b0, 0); model_op(o, es); do_op(o, es, nc);
        o = mk(2'd1, 3'd2, 32'h200, 0, 5'd10, 1'b1, 0); model_op(o, es); do_op(o, es, nc);
        o = mk(2'd1, 3'd5, 32'h202, 0, 5'd11, 1'b1, 0); model_op(o, es); do_op(o, es, nc);

        // Misaligned / illegal accesses.
        o = mk(2'd1, 3'd2, 32'h101, 0, 5'd12, 1'b1, 0); model_op(o, es); do_op(o, es, nc);
        o = mk(2'd1, 3'd1, 32'h003, 0, 5'd13, 1'b1, 0); model_op(o, es); do_op(o, es, nc);
        o = mk(2'd1, 3'd3, 32'h040, 0, 5'd14, 1'b1, 0); model_op(o, es); do_op(o, es, nc);

        // Randomized mix.
        for (int n = 0; n < 120; n++) begin
            int unsigned sz, r;
            o.kind = 2'($urandom_range(0, 2));
            r = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) o.f3 = 3'($urandom);
            else if (o.kind == 2'd1) o.f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            else o.f3 = 3'($urandom_range(0, 2));
            o.addr = $urandom_range(0, 1023);
            sz = (o.f3[1:0] == 2'd0) ? 1 : (o.f3[1:0] == 2'd1) ? 2 : 4;
            if ($urandom_range(0, 3) != 0) o.addr = o.addr & ~(sz - 1);
            o.wdata = $urandom; o.rd = 5'($urandom); o.wb_en = 1'($urandom); o.alu = $urandom;
            gnt_dly = $urandom_range(0, 3); rv_dly = $urandom_range(0, 3);
            model_op(o, es);
            do_op(o, es, nc);
        end

        // Timeout: no grant ever.
        no_gnt = 1'b1;
        err_q.push_back(1);
        o = mk(2'd1, 3'd2, 32'h040, 0, 5'd3, 1'b1, 0);
        do_op(o, -1, nc);
        check("tmo_err_cycle", nc, Tmo + 1);
        @(negedge clk);
        check_bit("tmo_bus_err", bus_err_o, 1'b1);
        check_bit("tmo_stall", stall_o, 1'b0);
        check_bit("tmo_req", bus_req_o, 1'b0);
        check_bit("tmo_wb_ena", reg_w_ena_o, 1'b0);
        @(posedge clk); #1;
        no_gnt = 1'b0;

        // Reset while waiting for the response; a late rvalid must be ignored.
        manual = 1'b1;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        bus_q.push_back('{addr: 32'h80, we: 1'b0, be: 4'hF, wdata: 32'h0});
        o = mk(2'd1, 3'd2, 32'h080, 0, 5'd7, 1'b1, 0);
        drive_op(o);
        nc = 0;
        do begin
            @(posedge clk); #1;
            nc++;
        end while (!bus_req_o && nc < 10);
        check_bit("rst_case_req", bus_req_o, 1'b1);
        bus_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        @(negedge clk);
        check_bit("resp_stall", stall_o, 1'b1);
        check_bit("resp_req_dropped", bus_req_o, 1'b0);
        @(posedge clk); #1;
        arst_n = 1'b0;
        drive_nop();
        @(posedge clk); #1;
        arst_n = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        check_bit("post_rst_req", bus_req_o, 1'b0);
        check_bit("post_rst_stall", stall_o, 1'b0);
        check_bit("post_rst_wb_ena", reg_w_ena_o, 1'b0);
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        check_bit("late_rvalid_no_wb", reg_w_ena_o, 1'b0);
        @(posedge clk); #1;
        manual = 1'b0;
        repeat (3) @(posedge clk);

        check("bus_q_drained", bus_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        check("mis_q_drained", mis_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
